fwnoc_router_egress_arb: RTL and testbench

- Packet-level arbiter and sequencer for one router egress port.
- Shares a single 32-bit ready/valid egress link between four ingress requesters (i0..i3).
- Selects a requester round-robin and decodes the payload size from the header flit. It then holds the connection until the whole packet has transferred.
- Instantiated once per egress direction inside the router, between the ingress buffers and the output link.

---
 rtl/fwnoc_pkg.sv | 27 ++
 rtl/fwnoc_router_egress_arb_if.sv | 22 ++
 rtl/fwnoc_rr_arb4.sv | 34 +++
 rtl/fwnoc_router_egress_arb.sv | 126 ++++++++++++
 tb/tb_fwnoc_router_egress_arb.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwnoc_pkg.sv
// ---------------------------------------------------------------------------
// fwnoc_pkg
//   Shared definitions for the fwnoc router datapath.
//   - Flit width and header payload-size field location.
//   - State encoding of the egress packet arbiter.
//   - Header size-field extraction, shared with the ingress decoders.
// ---------------------------------------------------------------------------
package fwnoc_pkg;

    localparam int FWNOC_FLIT_W   = 32;
    localparam int FWNOC_SIZE_LSB = 0;
    localparam int FWNOC_SIZE_W   = 8;

    typedef enum logic [1:0] {
        EARB_IDLE    = 2'd0,
        EARB_HEADER  = 2'd1,
        EARB_PAYLOAD = 2'd2
    } earb_state_t;

    // Payload flit count carried in a header flit.
    function automatic logic [FWNOC_SIZE_W-1:0] fwnoc_hdr_size(
        input logic [FWNOC_FLIT_W-1:0] hdr
    );
        return hdr[FWNOC_SIZE_LSB +: FWNOC_SIZE_W];
    endfunction

endpackage

// File: rtl/fwnoc_router_egress_arb_if.sv
// ---------------------------------------------------------------------------
// fwnoc_router_egress_arb_if
//   One ready/valid flit link.
//   dat   : flit payload (DATA_W bits), driven by the master
//   valid : flit present, driven by the master
//   ready : flit accepted this cycle, driven by the slave
//   A transfer happens on a rising clock edge with valid && ready.
// ---------------------------------------------------------------------------
interface fwnoc_router_egress_arb_if
    import fwnoc_pkg::*;
#(
    parameter int DATA_W = FWNOC_FLIT_W
);

    logic [DATA_W-1:0] dat;
    logic              valid;
    logic              ready;

    modport master (output dat, output valid, input  ready);
    modport slave  (input  dat, input  valid, output ready);

endinterface

// File: rtl/fwnoc_rr_arb4.sv
// ---------------------------------------------------------------------------
// fwnoc_rr_arb4
//   Combinational 4-way round-robin picker.
//   req     : request vector, bit n = requester n
//   last    : index granted most recently
//   gnt_idx : first requester found searching from last+1 upward with wrap
//   gnt_vld : at least one request present (gnt_idx meaningless otherwise)
// ---------------------------------------------------------------------------
module fwnoc_rr_arb4
    import fwnoc_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld
);

    logic [1:0] cand;

    // Walk candidates from lowest priority (last itself) to highest
    // (last+1); the final match written wins, giving the nearest one.
    always_comb begin
        gnt_idx = 2'd0;
        gnt_vld = |req;
        cand    = last;
        for (int k = 3; k >= 0; k--) begin
            cand = last + 2'(k + 1);
            if (req[cand]) begin
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/fwnoc_router_egress_arb.sv
// ---------------------------------------------------------------------------
// fwnoc_router_egress_arb
//   Packet-level arbiter for one router egress port. Four ingress links
//   share one egress link; a requester is chosen round-robin, the payload
//   size is taken from its header flit and the connection is held until
//   all N+1 flits of the packet have transferred.
//
//   clock    : clock
//   reset    : asynchronous, active-high reset
//   i0..i3   : ingress flit links (slave side: dat/valid in, ready out)
//   e        : egress flit link (master side: dat/valid out, ready in)
//
//   While connected the granted ingress is wired straight through to the
//   egress (zero-cycle path). Every packet is preceded by one IDLE cycle
//   in which the next requester is picked.
// ---------------------------------------------------------------------------
module fwnoc_router_egress_arb
    import fwnoc_pkg::*;
#(
    parameter int DATA_W   = FWNOC_FLIT_W,
    parameter int SIZE_LSB = FWNOC_SIZE_LSB,
    parameter int SIZE_W   = FWNOC_SIZE_W
)(
    input  logic                         clock,
    input  logic                         reset,
    fwnoc_router_egress_arb_if.slave     i0,
    fwnoc_router_egress_arb_if.slave     i1,
    fwnoc_router_egress_arb_if.slave     i2,
    fwnoc_router_egress_arb_if.slave     i3,
    fwnoc_router_egress_arb_if.master    e
);

    earb_state_t        state;
    logic [1:0]         grant;
    logic [1:0]         last_grant;
    logic [SIZE_W-1:0]  count;

    logic [DATA_W-1:0]  in_dat [4];
    logic [3:0]         in_vld;
    logic [3:0]         rdy_vec;

    logic [1:0]         pick_idx;
    logic               pick_vld;

    logic               connected;
    logic [DATA_W-1:0]  sel_dat;
    logic               sel_vld;
    logic               xfer;
    logic [SIZE_W-1:0]  hdr_n;

    assign in_dat[0] = i0.dat;
    assign in_dat[1] = i1.dat;
    assign in_dat[2] = i2.dat;
    assign in_dat[3] = i3.dat;
    assign in_vld    = {i3.valid, i2.valid, i1.valid, i0.valid};

    fwnoc_rr_arb4 u_rr (
        .req     (in_vld),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    assign connected = (state != EARB_IDLE);
    assign sel_dat   = in_dat[grant];
    assign sel_vld   = in_vld[grant];
    assign xfer      = connected && sel_vld && e.ready;
    assign hdr_n     = sel_dat[SIZE_LSB +: SIZE_W];

    // Egress valid never looks at e.ready; data is forced to zero in IDLE
    // so a stale flit never sits on the link between packets.
    assign e.valid = connected && sel_vld;
    assign e.dat   = connected ? sel_dat : '0;

    // Only the granted ingress sees the sink's ready; others must hold.
    always_comb begin
        rdy_vec = '0;
        if (connected) begin
            rdy_vec[grant] = e.ready;
        end
    end

    assign i0.ready = rdy_vec[0];
    assign i1.ready = rdy_vec[1];
    assign i2.ready = rdy_vec[2];
    assign i3.ready = rdy_vec[3];

    // count holds the payload flits still owed; it is loaded with N on the
    // header transfer, so N=255 fits without needing an extra bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= EARB_IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;
            count      <= '0;
        end else begin
            case (state)
                EARB_IDLE: begin
                    if (pick_vld) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        state      <= EARB_HEADER;
                    end
                end
                EARB_HEADER: begin
                    if (xfer) begin
                        count <= hdr_n;
                        state <= (hdr_n == '0) ? EARB_IDLE : EARB_PAYLOAD;
                    end
                end
                EARB_PAYLOAD: begin
                    if (xfer) begin
                        count <= count - 1'b1;
                        if (count == SIZE_W'(1)) begin
                            state <= EARB_IDLE;
                        end
                    end
                end
                default: begin
                    state <= EARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwnoc_router_egress_arb.sv
// ---------------------------------------------------------------------------
// tb_fwnoc_router_egress_arb
//   Self-checking bench for fwnoc_router_egress_arb. Ingress packets are
//   queued per port; the egress flits expected in order are kept in a
//   scoreboard queue and checked against the link every cycle.
// ---------------------------------------------------------------------------
module tb_fwnoc_router_egress_arb;

    typedef struct {
        int          port;
        logic [31:0] dat;
        bit          hdr;
    } sb_item_t;

    typedef struct {
        int          port;
        int          n;
        logic [7:0]  er_mask;
        logic [7:0]  v_mask;
        int          exp_calls;
        int          exp_hdr_tc;
    } vec_t;

    logic clock;
    logic reset;

    fwnoc_router_egress_arb_if #(.DATA_W(32)) if_i0 ();
    fwnoc_router_egress_arb_if #(.DATA_W(32)) if_i1 ();
    fwnoc_router_egress_arb_if #(.DATA_W(32)) if_i2 ();
    fwnoc_router_egress_arb_if #(.DATA_W(32)) if_i3 ();
    fwnoc_router_egress_arb_if #(.DATA_W(32)) if_e ();

    logic [31:0] drv_dat [4];
    logic        drv_vld [4];
    logic        drv_er;
    logic        rdy [4];

    assign if_i0.dat   = drv_dat[0];
    assign if_i0.valid = drv_vld[0];
    assign if_i1.dat   = drv_dat[1];
    assign if_i1.valid = drv_vld[1];
    assign if_i2.dat   = drv_dat[2];
    assign if_i2.valid = drv_vld[2];
    assign if_i3.dat   = drv_dat[3];
    assign if_i3.valid = drv_vld[3];
    assign rdy[0]      = if_i0.ready;
    assign rdy[1]      = if_i1.ready;
    assign rdy[2]      = if_i2.ready;
    assign rdy[3]      = if_i3.ready;
    assign if_e.ready  = drv_er;

    fwnoc_router_egress_arb dut (
        .clock (clock),
        .reset (reset),
        .i0    (if_i0),
        .i1    (if_i1),
        .i2    (if_i2),
        .i3    (if_i3),
        .e     (if_e)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [31:0] src_q [4][$];
    sb_item_t    sb [$];
    int          hdr_q [$];
    bit          acc [4];
    int          tc;
    int          xfer_cnt;
    int          n_cmp;
    int          n_bad;
    logic [7:0]  er_mask;
    logic [7:0]  v_mask;
    vec_t        vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            if (src_q[p].size() > 0) begin
                drv_dat[p] = src_q[p][0];
                drv_vld[p] = v_mask[tc % 8];
            end else begin
                drv_dat[p] = 32'h0;
                drv_vld[p] = 1'b0;
            end
        end
        drv_er = er_mask[tc % 8];
    endtask

    // Checks the link against the scoreboard front, away from the edge.
    task automatic monitor();
        sb_item_t f;
        bit       any_v;
        any_v = 1'b0;
        for (int p = 0; p < 4; p++) any_v = any_v | drv_vld[p];
        if (sb.size() == 0) begin
            chk("idle_evalid", {31'b0, if_e.valid}, 32'd0);
            for (int p = 0; p < 4; p++) chk($sformatf("idle_ready%0d", p), {31'b0, rdy[p]}, 32'd0);
        end else begin
            f = sb[0];
            for (int p = 0; p < 4; p++) begin
                if (p != f.port) chk($sformatf("ungranted_ready%0d", p), {31'b0, rdy[p]}, 32'd0);
            end
            if (if_e.valid) begin
                chk("egress_dat", if_e.dat, f.dat);
                chk("granted_ready", {31'b0, rdy[f.port]}, {31'b0, drv_er});
                if (drv_er) begin
                    void'(sb.pop_front());
                    xfer_cnt++;
                    if (f.hdr) hdr_q.push_back(tc);
                end
            end else if (v_mask[tc % 8] && any_v) begin
                chk("idle_dat_zero", if_e.dat, 32'd0);
            end
        end
        for (int p = 0; p < 4; p++) acc[p] = drv_vld[p] && rdy[p];
    endtask

    task automatic cycle();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (acc[p]) void'(src_q[p].pop_front());
        end
        tc++;
        drive();
    endtask

    task automatic load_pkt(input int p, input int n, input int id);
        sb_item_t it;
        logic [31:0] w;
        w = {4'hA, 4'(p), 8'(id), 8'h00, 8'(n)};
        src_q[p].push_back(w);
        it.port = p; it.dat = w; it.hdr = 1'b1;
        sb.push_back(it);
        for (int j = 1; j <= n; j++) begin
            w = {4'h5, 4'(p), 8'(id), 16'(j)};
            src_q[p].push_back(w);
            it.port = p; it.dat = w; it.hdr = 1'b0;
            sb.push_back(it);
        end
    endtask

    task automatic begin_test(input logic [7:0] er, input logic [7:0] vm);
        tc       = 0;
        xfer_cnt = 0;
        hdr_q.delete();
        er_mask  = er;
        v_mask   = vm;
    endtask

    task automatic run_done(input int limit, output int calls);
        calls = 0;
        while (sb.size() > 0 && calls < limit) begin
            cycle();
            calls++;
        end
        if (sb.size() > 0) begin
            chk("timeout_flits_left", sb.size(), 32'd0);
            sb.delete();
            for (int p = 0; p < 4; p++) src_q[p].delete();
            drive();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int calls;
        n_cmp = 0;
        n_bad = 0;
        tc    = 0;
        er_mask = 8'hFF;
        v_mask  = 8'hFF;
        for (int p = 0; p < 4; p++) begin
            drv_dat[p] = 32'h0;
            drv_vld[p] = 1'b0;
            acc[p]     = 1'b0;
        end
        drv_er = 1'b0;

        //                port  n   er_mask v_mask calls hdr_tc
        vecs[0] = '{2,    3,   8'hFF,  8'hFF,  5,    1};
        vecs[1] = '{1,    2,   8'hEB,  8'hFF,  6,    1};
        vecs[2] = '{0,    255, 8'hFF,  8'hFF,  257,  1};
        vecs[3] = '{3,    0,   8'hFF,  8'hFF,  2,    1};
        vecs[4] = '{1,    1,   8'hFD,  8'hFF,  4,    2};
        vecs[5] = '{0,    2,   8'hFF,  8'hFB,  5,    1};

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_evalid", {31'b0, if_e.valid}, 32'd0);
        chk("rst_edat", if_e.dat, 32'd0);
        for (int p = 0; p < 4; p++) chk($sformatf("rst_ready%0d", p), {31'b0, rdy[p]}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single-packet vectors
        for (int i = 0; i < 6; i++) begin
            begin_test(vecs[i].er_mask, vecs[i].v_mask);
            load_pkt(vecs[i].port, vecs[i].n, i);
            drive();
            run_done(vecs[i].exp_calls + 20, calls);
            chk($sformatf("v%0d_calls", i), calls, vecs[i].exp_calls);
            chk($sformatf("v%0d_flits", i), xfer_cnt, vecs[i].n + 1);
            chk($sformatf("v%0d_hdr_cycle", i), (hdr_q.size() > 0) ? hdr_q[0] : -1, vecs[i].exp_hdr_tc);
            cycle();
            chk($sformatf("v%0d_src_drained", i), src_q[vecs[i].port].size(), 32'd0);
        end

        // i3 arrives while an i0 N=5 packet is in flight
        begin_test(8'hFF, 8'hFF);
        load_pkt(0, 5, 10);
        drive();
        repeat (3) cycle();
        load_pkt(3, 0, 11);
        drive();
        run_done(40, calls);
        chk("mid_flits", xfer_cnt, 32'd7);
        chk("mid_hdr_count", hdr_q.size(), 32'd2);
        chk("mid_i0_hdr_cycle", (hdr_q.size() > 0) ? hdr_q[0] : -1, 32'd1);
        chk("mid_i3_hdr_cycle", (hdr_q.size() > 1) ? hdr_q[1] : -1, 32'd8);
        cycle();

        // Reset in the middle of an i2 N=3 packet
        begin_test(8'hFF, 8'hFF);
        load_pkt(2, 3, 20);
        drive();
        repeat (3) cycle();
        chk("abort_flits_before_reset", xfer_cnt, 32'd2);
        reset = 1'b1;
        #1;
        chk("abort_evalid", {31'b0, if_e.valid}, 32'd0);
        chk("abort_edat", if_e.dat, 32'd0);
        for (int p = 0; p < 4; p++) chk($sformatf("abort_ready%0d", p), {31'b0, rdy[p]}, 32'd0);
        sb.delete();
        for (int p = 0; p < 4; p++) src_q[p].delete();
        drive();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // All four request with N=0 packets: rotation 0,1,2,3,0
        begin_test(8'hFF, 8'hFF);
        load_pkt(0, 0, 30);
        load_pkt(1, 0, 31);
        load_pkt(2, 0, 32);
        load_pkt(3, 0, 33);
        load_pkt(0, 0, 34);
        drive();
        run_done(40, calls);
        chk("rot_hdr_count", hdr_q.size(), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rot_hdr%0d_cycle", k), (hdr_q.size() > k) ? hdr_q[k] : -1, 1 + 2 * k);
        end
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
